// File: rtl/rx_data_deframer.sv
// Single-lane RX deframer: classifies descrambled 66-bit blocks and rebuilds
// AXI-Stream frames through a one-entry holding buffer so tlast is known early.
module rx_data_deframer #(
    parameter int INTERMEDIATE_DATA_SIZE = 66,
    parameter int AXI_DATA_SIZE          = 64,
    parameter int KEEP_SIZE              = AXI_DATA_SIZE / 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              channel_up,
    input  logic                              rx_block_valid,
    input  logic [INTERMEDIATE_DATA_SIZE-1:0] rx_block,
    output logic                              m_axi_valid,
    output logic [AXI_DATA_SIZE-1:0]          m_axi_data,
    output logic [KEEP_SIZE-1:0]              m_axi_keep,
    output logic                              m_axi_last,
    output logic                              os_idle,
    output logic                              os_cc,
    output logic                              os_cb,
    output logic                              os_nr,
    output logic                              sync_err,
    output logic                              frame_err
);

    localparam logic [7:0] T_IDLE = 8'h78;
    localparam logic [7:0] T_SEP  = 8'h1E;
    localparam logic [7:0] T_SEP7 = 8'hE1;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t                   state, nxt_state;
    logic                     buf_valid, nxt_buf_valid;
    logic                     buf_last, nxt_buf_last;
    logic [AXI_DATA_SIZE-1:0] buf_data, nxt_buf_data;
    logic [KEEP_SIZE-1:0]     buf_keep, nxt_buf_keep;

    logic                     nxt_valid, nxt_last;
    logic [AXI_DATA_SIZE-1:0] nxt_data;
    logic [KEEP_SIZE-1:0]     nxt_keep;
    logic                     nxt_idle, nxt_cc, nxt_cb, nxt_nr, nxt_sync_err, nxt_frame_err;

    logic [1:0]               sync;
    logic [7:0]               ctype, sep_n;
    logic                     is_data, is_ctl, is_idle, is_sep, is_sep7, is_sep0, is_tail;
    logic [AXI_DATA_SIZE-1:0] tail_raw, tail_data;
    logic [KEEP_SIZE-1:0]     tail_keep;

    assign sync    = rx_block[INTERMEDIATE_DATA_SIZE-1 -: 2];
    assign ctype   = rx_block[63:56];
    assign sep_n   = rx_block[55:48];
    assign is_data = (sync == 2'b01);
    assign is_ctl  = (sync == 2'b10);
    assign is_idle = is_ctl && (ctype == T_IDLE);
    assign is_sep  = is_ctl && (ctype == T_SEP);
    assign is_sep7 = is_ctl && (ctype == T_SEP7);
    assign is_sep0 = is_sep && (sep_n == 8'd0);
    assign is_tail = (is_sep && (sep_n != 8'd0) && (sep_n <= 8'd6)) || is_sep7;

    // Tail bytes are left-aligned; bytes beyond the count are forced to zero.
    assign tail_raw  = is_sep7 ? {rx_block[55:0], 8'h00} : {rx_block[47:0], 16'h0000};
    assign tail_keep = is_sep7 ? 8'hFE : ~({KEEP_SIZE{1'b1}} >> sep_n);

    always_comb begin
        tail_data = '0;
        for (int i = 0; i < KEEP_SIZE; i++)
            if (tail_keep[i]) tail_data[8*i +: 8] = tail_raw[8*i +: 8];
    end

    always_comb begin
        nxt_state     = state;
        nxt_buf_valid = buf_valid;
        nxt_buf_last  = buf_last;
        nxt_buf_data  = buf_data;
        nxt_buf_keep  = buf_keep;
        nxt_valid     = 1'b0;
        nxt_data      = '0;
        nxt_keep      = '0;
        nxt_last      = 1'b0;
        nxt_idle      = 1'b0;
        nxt_cc        = 1'b0;
        nxt_cb        = 1'b0;
        nxt_nr        = 1'b0;
        nxt_sync_err  = 1'b0;
        nxt_frame_err = 1'b0;

        // A last entry only lives in IDLE, so it can never collide with an IN_FRAME emit.
        if (buf_valid && buf_last) begin
            nxt_valid     = 1'b1;
            nxt_data      = buf_data;
            nxt_keep      = buf_keep;
            nxt_last      = 1'b1;
            nxt_buf_valid = 1'b0;
        end

        if (!channel_up) begin
            nxt_buf_valid = 1'b0;
            nxt_state     = IDLE;
        end else if (rx_block_valid) begin
            if (!is_data && !is_ctl) begin
                nxt_sync_err = 1'b1;
            end else if (is_data) begin
                if (state == IN_FRAME) begin
                    nxt_valid = 1'b1;
                    nxt_data  = buf_data;
                    nxt_keep  = buf_keep;
                end
                nxt_buf_valid = 1'b1;
                nxt_buf_last  = 1'b0;
                nxt_buf_data  = rx_block[AXI_DATA_SIZE-1:0];
                nxt_buf_keep  = '1;
                nxt_state     = IN_FRAME;
            end else if (is_idle) begin
                nxt_idle = 1'b1;
                nxt_cc   = rx_block[48];
                nxt_cb   = rx_block[49];
                nxt_nr   = rx_block[50];
            end else if (is_tail) begin
                if (state == IN_FRAME) begin
                    nxt_valid = 1'b1;
                    nxt_data  = buf_data;
                    nxt_keep  = buf_keep;
                end
                nxt_buf_valid = 1'b1;
                nxt_buf_last  = 1'b1;
                nxt_buf_data  = tail_data;
                nxt_buf_keep  = tail_keep;
                nxt_state     = IDLE;
            end else if (is_sep0) begin
                if (state == IN_FRAME) begin
                    nxt_valid     = 1'b1;
                    nxt_data      = buf_data;
                    nxt_keep      = buf_keep;
                    nxt_last      = 1'b1;
                    nxt_buf_valid = 1'b0;
                end
                nxt_state = IDLE;
            end else begin
                nxt_frame_err = 1'b1;
                nxt_buf_valid = 1'b0;
                nxt_state     = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            buf_valid   <= 1'b0;
            buf_last    <= 1'b0;
            buf_data    <= '0;
            buf_keep    <= '0;
            m_axi_valid <= 1'b0;
            m_axi_data  <= '0;
            m_axi_keep  <= '0;
            m_axi_last  <= 1'b0;
            os_idle     <= 1'b0;
            os_cc       <= 1'b0;
            os_cb       <= 1'b0;
            os_nr       <= 1'b0;
            sync_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= nxt_state;
            buf_valid   <= nxt_buf_valid;
            buf_last    <= nxt_buf_last;
            buf_data    <= nxt_buf_data;
            buf_keep    <= nxt_buf_keep;
            m_axi_valid <= nxt_valid;
            m_axi_data  <= nxt_data;
            m_axi_keep  <= nxt_keep;
            m_axi_last  <= nxt_last;
            os_idle     <= nxt_idle;
            os_cc       <= nxt_cc;
            os_cb       <= nxt_cb;
            os_nr       <= nxt_nr;
            sync_err    <= nxt_sync_err;
            frame_err   <= nxt_frame_err;
        end
    end

endmodule

// File: tb/tb_rx_data_deframer.sv
// Directed, table-driven bench for rx_data_deframer with hand-computed beats.
module tb_rx_data_deframer;

    logic        clk = 1'b0;
    logic        rst;
    logic        channel_up;
    logic        rx_block_valid;
    logic [65:0] rx_block;
    logic        m_axi_valid;
    logic [63:0] m_axi_data;
    logic [7:0]  m_axi_keep;
    logic        m_axi_last;
    logic        os_idle, os_cc, os_cb, os_nr, sync_err, frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    rx_data_deframer dut (
        .clk            (clk),
        .rst            (rst),
        .channel_up     (channel_up),
        .rx_block_valid (rx_block_valid),
        .rx_block       (rx_block),
        .m_axi_valid    (m_axi_valid),
        .m_axi_data     (m_axi_data),
        .m_axi_keep     (m_axi_keep),
        .m_axi_last     (m_axi_last),
        .os_idle        (os_idle),
        .os_cc          (os_cc),
        .os_cb          (os_cb),
        .os_nr          (os_nr),
        .sync_err       (sync_err),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    // flags = {os_idle, os_cc, os_cb, os_nr, sync_err, frame_err}
    typedef struct {
        logic        cu;
        logic        vld;
        logic [65:0] blk;
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        el;
        logic [5:0]  ef;
    } vec_t;

    vec_t vt[$];

    localparam logic [63:0] DA = 64'hA0A1A2A3A4A5A6A7;
    localparam logic [63:0] DB = 64'hB0B1B2B3B4B5B6B7;
    localparam logic [63:0] DC = 64'hC0C1C2C3C4C5C6C7;

    function automatic logic [65:0] dblk(input logic [63:0] d);
        return {2'b01, d};
    endfunction
    function automatic logic [65:0] cblk(input logic [7:0] t, input logic [55:0] p);
        return {2'b10, t, p};
    endfunction
    function automatic logic [65:0] sep(input logic [7:0] n, input logic [47:0] b);
        return cblk(8'h1E, {n, b});
    endfunction
    function automatic logic [65:0] idl(input logic [2:0] f);
        return cblk(8'h78, {5'b0, f, 48'h0});
    endfunction

    task automatic add(input logic cu, input logic vld, input logic [65:0] blk,
                       input logic ev, input logic [63:0] ed, input logic [7:0] ek,
                       input logic el, input logic [5:0] ef);
        vec_t v;
        v.cu = cu; v.vld = vld; v.blk = blk;
        v.ev = ev; v.ed = ed; v.ek = ek; v.el = el; v.ef = ef;
        vt.push_back(v);
    endtask

    function automatic logic [79:0] snap();
        return {m_axi_valid, m_axi_data, m_axi_keep, m_axi_last,
                os_idle, os_cc, os_cb, os_nr, sync_err, frame_err};
    endfunction

    task automatic check(input string name, input logic [79:0] exp);
        logic [79:0] act;
        act = snap();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cu, input logic vld, input logic [65:0] blk);
        @(negedge clk);
        channel_up     = cu;
        rx_block_valid = vld;
        rx_block       = blk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; channel_up = 1'b0; rx_block_valid = 1'b0; rx_block = '0;

        // Frame A, B, SEP n=3
        add(1, 1, dblk(DA),                  0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 1, dblk(DB),                  1, DA,    8'hFF, 0, 6'b000000);
        add(1, 1, sep(8'd3, 48'h112233_000000), 1, DB, 8'hFF, 0, 6'b000000);
        add(1, 0, '0,                        1, 64'h1122330000000000, 8'hE0, 1, 6'b000000);
        add(1, 0, '0,                        0, 64'h0, 8'h00, 0, 6'b000000);
        // Idles inside a frame hold the buffer
        add(1, 1, dblk(DA),                  0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 1, idl(3'b001),               0, 64'h0, 8'h00, 0, 6'b110000);
        add(1, 1, idl(3'b000),               0, 64'h0, 8'h00, 0, 6'b100000);
        add(1, 1, sep(8'd0, 48'h0),          1, DA,    8'hFF, 1, 6'b000000);
        // SEP7 then data C next cycle: tail and load happen together
        add(1, 1, cblk(8'hE1, 56'h01020304050607), 0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 1, dblk(DC),                  1, 64'h0102030405060700, 8'hFE, 1, 6'b000000);
        add(1, 0, '0,                        0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 1, sep(8'd0, 48'h0),          1, DC,    8'hFF, 1, 6'b000000);
        // Bad sync header in a frame
        add(1, 1, dblk(DA),                  0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 1, {2'b11, 64'h1E00000000000000}, 0, 64'h0, 8'h00, 0, 6'b000010);
        add(1, 1, sep(8'd0, 48'h0),          1, DA,    8'hFF, 1, 6'b000000);
        // SEP n=9 aborts the frame; then SEP n=2 with garbage beyond the tail
        add(1, 1, dblk(DA),                  0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 1, sep(8'd9, 48'h0),          0, 64'h0, 8'h00, 0, 6'b000001);
        add(1, 1, sep(8'd2, 48'hAABBCCDDEEFF), 0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 0, '0,                        1, 64'hAABB000000000000, 8'hC0, 1, 6'b000000);
        // channel_up drop mid-frame discards the buffer
        add(1, 1, dblk(DA),                  0, 64'h0, 8'h00, 0, 6'b000000);
        add(0, 0, '0,                        0, 64'h0, 8'h00, 0, 6'b000000);
        add(0, 1, dblk(DB),                  0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 1, sep(8'd0, 48'h0),          0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 0, '0,                        0, 64'h0, 8'h00, 0, 6'b000000);
        // Idle flags nr/cb, SEP n=6 boundary, unknown type
        add(1, 1, idl(3'b110),               0, 64'h0, 8'h00, 0, 6'b101100);
        add(1, 1, dblk(DA),                  0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 1, sep(8'd6, 48'h010203040506), 1, DA, 8'hFF, 0, 6'b000000);
        add(1, 0, '0,                        1, 64'h0102030405060000, 8'hFC, 1, 6'b000000);
        add(1, 1, cblk(8'h55, 56'h0),        0, 64'h0, 8'h00, 0, 6'b000001);
        add(1, 1, dblk(DA),                  0, 64'h0, 8'h00, 0, 6'b000000);
        add(1, 1, cblk(8'h55, 56'h0),        0, 64'h0, 8'h00, 0, 6'b000001);
        add(1, 1, sep(8'd0, 48'h0),          0, 64'h0, 8'h00, 0, 6'b000000);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 80'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].cu, vt[i].vld, vt[i].blk);
            check($sformatf("vec%0d", i), {vt[i].ev, vt[i].ed, vt[i].ek, vt[i].el, vt[i].ef});
        end

        // Asynchronous reset while a beat is on the bus and a frame is buffered
        drive(1, 1, dblk(DA));
        drive(1, 1, dblk(DB));
        check("pre_rst_beat", {1'b1, DA, 8'hFF, 1'b0, 6'b0});
        @(negedge clk);
        rx_block_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_clear", 80'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, sep(8'd0, 48'h0));
        check("rst_lost_buffer", 80'h0);
        drive(1, 0, '0);
        check("rst_idle_after", 80'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_data_deframer.md
Name: rx_data_deframer

Overview:
- Receive-side counterpart of the TX data/ordered-set path for a single lane.
- Takes descrambled 66-bit blocks (sync header + 64-bit payload) from the lane receive logic and classifies each one as data, separator (SEP/SEP7) or Idle ordered set.
- Reassembles user frames onto an AXI-Stream master (data/keep/last) with a one-block holding buffer, so the end of a frame is known before its last beat goes out.
- Reports decoded ordered sets and protocol errors.

Parameters:
- INTERMEDIATE_DATA_SIZE, 66: block width; bits [65:64] are the sync header.
- AXI_DATA_SIZE, 64: output data width; always 8 bytes.
- KEEP_SIZE, AXI_DATA_SIZE/8: tkeep width.

Ports:
- clk  in  1  Single clock domain.
- rst  in  1  Asynchronous, active-high reset.
- channel_up  in  1  Channel initialisation finished; blocks are ignored while low.
- rx_block_valid  in  1  rx_block carries a new block this cycle.
- rx_block  in  INTERMEDIATE_DATA_SIZE  Received block.
- m_axi_valid  out  1  Output beat valid; no backpressure.
- m_axi_data  out  AXI_DATA_SIZE  Payload; byte0 is in [63:56].
- m_axi_keep  out  KEEP_SIZE  Byte enables, MSB = byte0.
- m_axi_last  out  1  Last beat of frame.
- os_idle, os_cc, os_cb, os_nr  out  1 each  One-cycle pulses on a decoded Idle block and its flags.
- sync_err  out  1  One-cycle pulse: sync header 2'b00 or 2'b11.
- frame_err  out  1  One-cycle pulse: unknown block type or SEP count > 6.

Behaviour:
- Reset: all outputs 0, buffer empty, state IDLE. Every output is registered and updated on the clk edge that samples the input.
- Decoding:
  - Sync 2'b01 is a data block; the payload goes to bytes 0..7, keep 8'hFF.
  - Sync 2'b10 is a control block; the type is in [63:56].
  - 0x78 = Idle; flags {nr,cb,cc} are in [50:48].
  - 0x1E = SEP; count n is in [55:48]; bytes 0..n-1 are in [47:0] from MSB.
  - 0xE1 = SEP7; 7 bytes are in [55:0].
- Output packing: tail bytes are left-aligned in m_axi_data and the remaining bytes are 0. keep = n MSB ones (n=3 gives 8'hE0, SEP7 gives 8'hFE).
- Buffer: one entry {data, keep, last}.
  - A non-last entry is emitted only when the next data or SEP block arrives.
  - A last entry is emitted on the next clock unconditionally.
- State IDLE (no frame in progress):
  - Data block: buffer it (non-last), go to IN_FRAME.
  - SEP with n in 1..6, or SEP7: buffer the tail as last, stay in IDLE.
  - SEP with n = 0: drop it, no output, no error.
- State IN_FRAME:
  - Data block: emit the buffer with last=0, buffer the new block.
  - SEP n = 0: emit the buffer with last=1, buffer becomes empty, go to IDLE.
  - SEP n in 1..6, or SEP7: emit the buffer with last=0, buffer the tail as last, go to IDLE.
- Idle blocks never emit beats or change state, in either state. Idles inside a frame simply hold the buffer. os_idle pulses, and os_cc/os_cb/os_nr pulse with their flags.
- Simultaneous events: when a last entry is pending and a new data or SEP block arrives in the same cycle, emit the last entry and load the new block in that same cycle. No beat is ever lost, and at most one beat is emitted per cycle.
- Errors:
  - Bad sync header: pulse sync_err, drop the block, state unchanged.
  - Unknown type, or SEP with n > 6: pulse frame_err, discard the buffer (a pending last entry is still emitted), go to IDLE.
- channel_up low: blocks are ignored; on the falling edge a pending non-last buffer is discarded (a pending last entry is still emitted) and state goes to IDLE. No m_axi_last is emitted for an aborted frame.
- rst asserted mid-frame: outputs clear asynchronously and buffered data is lost.

Test Plan:
- Frame: data A, data B, SEP n=3 (bytes 11 22 33). Expect beats A(keep FF, last 0), B(FF, 0), then 0x112233_0000000000 with keep E0 and last 1, on consecutive cycles after each arrival.
- Data A, Idle(cc=1), Idle, SEP n=0. Expect os_idle to pulse twice and os_cc once; A is emitted only at the SEP, with last=1.
- SEP7 (bytes 01..07) then immediately data C in the next cycle. Expect the tail beat (keep FE, last 1) followed by no beat for C until C's frame ends.
- Data A, block with sync 2'b11, SEP n=0. Expect sync_err one pulse and A emitted with last 1.
- Data A, SEP n=9. Expect frame_err and no beat for A; state returns to IDLE.
- Data A, channel_up dropped, then raised, then SEP n=0. Expect no output at all; rst pulse mid-frame clears every output within the same cycle.
